// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and helpers for the dual-port block RAM.
//   RD_LAT_MIN/RD_LAT_MAX  legal read-latency range
//   PAR_MAX_W              widest word the parity helper accepts
//   byte_lanes(w)          number of byte lanes in a w-bit word
//   parity_gen(word)       even-parity bit per byte lane (word zero-extended to PAR_MAX_W)
package mem_pkg;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;
   localparam int PAR_MAX_W  = 256;
   function automatic int byte_lanes(input int data_w);
      return data_w / 8;
   endfunction
   function automatic logic [PAR_MAX_W/8-1:0] parity_gen(input logic [PAR_MAX_W-1:0] word);
      logic [PAR_MAX_W/8-1:0] p;
      for (int k = 0; k < PAR_MAX_W/8; k++) p[k] = ^word[8*k +: 8];
      return p;
   endfunction
endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: read-output register chain of DEPTH stages (DEPTH=0 is a wire).
//   clk, rst         clock, synchronous active-high reset clearing every stage
//   vld_i/data_i/perr_i  strobe, word and parity flag from the array read register
//   vld_o/data_o/perr_o  delayed strobe, word and parity flag; data holds when no strobe
module mem_rd_pipe #(
   parameter int DEPTH = 0,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         vld_i,
   input  logic [W-1:0] data_i,
   input  logic         perr_i,
   output logic         vld_o,
   output logic [W-1:0] data_o,
   output logic         perr_o
);
   if (DEPTH == 0) begin : g_pass
      assign vld_o  = vld_i;
      assign data_o = data_i;
      assign perr_o = perr_i;
   end else begin : g_reg
      logic [DEPTH-1:0] vld_q, perr_q;
      logic [W-1:0]     data_q [DEPTH];
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q  <= '0;
            perr_q <= '0;
            for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
         end else begin
            vld_q[0] <= vld_i;
            if (vld_i) begin
               data_q[0] <= data_i;
               perr_q[0] <= perr_i;
            end
            for (int s = 1; s < DEPTH; s++) begin
               vld_q[s] <= vld_q[s-1];
               if (vld_q[s-1]) begin
                  data_q[s] <= data_q[s-1];
                  perr_q[s] <= perr_q[s-1];
               end
            end
         end
      end
      assign vld_o  = vld_q[DEPTH-1];
      assign data_o = data_q[DEPTH-1];
      assign perr_o = perr_q[DEPTH-1];
   end
endmodule

// File: rtl/mem_dp_bram.sv
// mem_dp_bram: true-dual-port block RAM, read-only fetch port I and byte-enabled data port D.
module mem_dp_bram
  import mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 13,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                I_Req,
  input  logic [ADDR_W-1:0]   I_Addr,
  output logic [DATA_W-1:0]   I_Out,
  output logic                I_Vld,
  input  logic                D_Req,
  input  logic                D_We,
  input  logic [DATA_W/8-1:0] D_Be,
  input  logic [ADDR_W-1:0]   D_Addr,
  input  logic [DATA_W-1:0]   D_In,
  output logic [DATA_W-1:0]   D_Out,
  output logic                D_Vld,
  output logic                I_Perr,
  output logic                D_Perr
);
  localparam int LANES = byte_lanes(DATA_W);
`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + LANES;
`else
  localparam int MEM_W = DATA_W;
`endif
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $fatal(1, "mem_dp_bram: RD_LAT must be 1 or 2");
  end
  logic [MEM_W-1:0] mem_q [2**ADDR_W];
  logic [MEM_W-1:0] i_rd_q, d_rd_q, wr_word;
  logic             i_vld_q, d_vld_q, i_perr, d_perr, d_rd, d_wr;
  assign d_rd = D_Req && !D_We;
  assign d_wr = D_Req && D_We && !rst;
`ifdef MEM_PARITY_EN
  logic [PAR_MAX_W/8-1:0] wr_par, i_par, d_par;
  assign wr_par  = parity_gen(PAR_MAX_W'(D_In));
  assign i_par   = parity_gen(PAR_MAX_W'(i_rd_q[DATA_W-1:0]));
  assign d_par   = parity_gen(PAR_MAX_W'(d_rd_q[DATA_W-1:0]));
  assign wr_word = {wr_par[LANES-1:0], D_In};
  assign i_perr  = |(i_par[LANES-1:0] ^ i_rd_q[MEM_W-1:DATA_W]);
  assign d_perr  = |(d_par[LANES-1:0] ^ d_rd_q[MEM_W-1:DATA_W]);
`else
  assign wr_word = D_In;
  assign i_perr  = 1'b0;
  assign d_perr  = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      i_vld_q <= 1'b0;
      i_rd_q  <= '0;
    end else begin
      i_vld_q <= I_Req;
      if (I_Req) i_rd_q <= mem_q[I_Addr];
    end
  end
  always_ff @(posedge clk) begin
    if (d_wr) begin
      for (int k = 0; k < LANES; k++) begin
        if (D_Be[k]) begin
          mem_q[D_Addr][8*k +: 8] <= wr_word[8*k +: 8];
`ifdef MEM_PARITY_EN
          mem_q[D_Addr][DATA_W+k] <= wr_word[DATA_W+k];
`endif
        end
      end
    end
    if (rst) begin
      d_vld_q <= 1'b0;
      d_rd_q  <= '0;
    end else begin
      d_vld_q <= d_rd;
      if (d_rd) d_rd_q <= mem_q[D_Addr];
    end
  end
  mem_rd_pipe #(.DEPTH(RD_LAT-1), .W(DATA_W)) u_i_pipe (
    .clk(clk), .rst(rst), .vld_i(i_vld_q), .data_i(i_rd_q[DATA_W-1:0]), .perr_i(i_perr),
    .vld_o(I_Vld), .data_o(I_Out), .perr_o(I_Perr)
  );
  mem_rd_pipe #(.DEPTH(RD_LAT-1), .W(DATA_W)) u_d_pipe (
    .clk(clk), .rst(rst), .vld_i(d_vld_q), .data_i(d_rd_q[DATA_W-1:0]), .perr_i(d_perr),
    .vld_o(D_Vld), .data_o(D_Out), .perr_o(D_Perr)
  );
endmodule

// File: tb/tb_mem_dp_bram.sv
// tb_mem_dp_bram: scoreboard bench driving one RD_LAT=1 and one RD_LAT=2 instance in lockstep.
module tb_mem_dp_bram;
   logic        clk = 1'b0, rst = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [12:0] i_addr = '0, d_addr = '0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_in = '0;
   logic [31:0] u1_i_out, u1_d_out, u2_i_out, u2_d_out;
   logic        u1_i_vld, u1_d_vld, u1_i_perr, u1_d_perr;
   logic        u2_i_vld, u2_d_vld, u2_i_perr, u2_d_perr;
   typedef struct { logic [31:0] d; logic p; int t; } exp_t;
   exp_t        qi1[$], qd1[$], qi2[$], qd2[$];
   exp_t        ei1, ed1, ei2, ed2;
   logic [31:0] model [8192];
   logic [31:0] hold1, hold2;
   logic        d_perr_exp = 1'b0;
   int          cyc = 0, n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_dp_bram #(.DATA_W(32), .ADDR_W(13), .RD_LAT(1)) u1 (
      .clk(clk), .rst(rst), .I_Req(i_req), .I_Addr(i_addr), .I_Out(u1_i_out), .I_Vld(u1_i_vld),
      .D_Req(d_req), .D_We(d_we), .D_Be(d_be), .D_Addr(d_addr), .D_In(d_in), .D_Out(u1_d_out),
      .D_Vld(u1_d_vld), .I_Perr(u1_i_perr), .D_Perr(u1_d_perr)
   );
   mem_dp_bram #(.DATA_W(32), .ADDR_W(13), .RD_LAT(2)) u2 (
      .clk(clk), .rst(rst), .I_Req(i_req), .I_Addr(i_addr), .I_Out(u2_i_out), .I_Vld(u2_i_vld),
      .D_Req(d_req), .D_We(d_we), .D_Be(d_be), .D_Addr(d_addr), .D_In(d_in), .D_Out(u2_d_out),
      .D_Vld(u2_d_vld), .I_Perr(u2_i_perr), .D_Perr(u2_d_perr)
   );

   // Scoreboard monitors: every Vld pulse pops one expectation and checks data, parity and latency.
   always @(negedge clk) if (u1_i_vld) begin
      n_cmp++;
      if (qi1.size() == 0) begin n_err++; $display("FAIL lat1_i_vld: unexpected pulse at cycle %0d", cyc); end
      else begin
         ei1 = qi1.pop_front();
         if (u1_i_out !== ei1.d || u1_i_perr !== ei1.p || cyc - ei1.t != 1) begin
            n_err++; $display("FAIL lat1_i_read: got %h perr %b lat %0d, want %h perr %b lat 1", u1_i_out, u1_i_perr, cyc - ei1.t, ei1.d, ei1.p);
         end
      end
   end
   always @(negedge clk) if (u1_d_vld) begin
      n_cmp++;
      if (qd1.size() == 0) begin n_err++; $display("FAIL lat1_d_vld: unexpected pulse at cycle %0d", cyc); end
      else begin
         ed1 = qd1.pop_front();
         if (u1_d_out !== ed1.d || u1_d_perr !== ed1.p || cyc - ed1.t != 1) begin
            n_err++; $display("FAIL lat1_d_read: got %h perr %b lat %0d, want %h perr %b lat 1", u1_d_out, u1_d_perr, cyc - ed1.t, ed1.d, ed1.p);
         end
      end
   end
   always @(negedge clk) if (u2_i_vld) begin
      n_cmp++;
      if (qi2.size() == 0) begin n_err++; $display("FAIL lat2_i_vld: unexpected pulse at cycle %0d", cyc); end
      else begin
         ei2 = qi2.pop_front();
         if (u2_i_out !== ei2.d || u2_i_perr !== ei2.p || cyc - ei2.t != 2) begin
            n_err++; $display("FAIL lat2_i_read: got %h perr %b lat %0d, want %h perr %b lat 2", u2_i_out, u2_i_perr, cyc - ei2.t, ei2.d, ei2.p);
         end
      end
   end
   always @(negedge clk) if (u2_d_vld) begin
      n_cmp++;
      if (qd2.size() == 0) begin n_err++; $display("FAIL lat2_d_vld: unexpected pulse at cycle %0d", cyc); end
      else begin
         ed2 = qd2.pop_front();
         if (u2_d_out !== ed2.d || u2_d_perr !== ed2.p || cyc - ed2.t != 2) begin
            n_err++; $display("FAIL lat2_d_read: got %h perr %b lat %0d, want %h perr %b lat 2", u2_d_out, u2_d_perr, cyc - ed2.t, ed2.d, ed2.p);
         end
      end
   end

   // Drives one cycle of stimulus, pushing read expectations from the model before applying writes.
   task automatic step(input logic ir, input logic [12:0] ia, input logic dr, input logic dw,
                       input logic [3:0] be, input logic [12:0] da, input logic [31:0] din);
      i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = be; d_addr = da; d_in = din;
      if (!rst) begin
         if (ir) begin
            qi1.push_back('{d: model[ia], p: 1'b0, t: cyc});
            qi2.push_back('{d: model[ia], p: 1'b0, t: cyc});
         end
         if (dr && !dw) begin
            qd1.push_back('{d: model[da], p: d_perr_exp, t: cyc});
            qd2.push_back('{d: model[da], p: d_perr_exp, t: cyc});
         end
         if (dr && dw) for (int k = 0; k < 4; k++) if (be[k]) model[da][8*k +: 8] = din[8*k +: 8];
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic drain_check(input string name);
      idle(3);
      n_cmp++; if (qi1.size() != 0) begin n_err++; $display("FAIL %s_lat1_i_missing: %0d pending, want 0", name, qi1.size()); end
      n_cmp++; if (qd1.size() != 0) begin n_err++; $display("FAIL %s_lat1_d_missing: %0d pending, want 0", name, qd1.size()); end
      n_cmp++; if (qi2.size() != 0) begin n_err++; $display("FAIL %s_lat2_i_missing: %0d pending, want 0", name, qi2.size()); end
      n_cmp++; if (qd2.size() != 0) begin n_err++; $display("FAIL %s_lat2_d_missing: %0d pending, want 0", name, qd2.size()); end
      qi1.delete(); qd1.delete(); qi2.delete(); qd2.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({u1_i_vld, u1_d_vld, u2_i_vld, u2_d_vld} !== 4'b0) begin
            n_err++; $display("FAIL reset_vld: got %b, want 0000", {u1_i_vld, u1_d_vld, u2_i_vld, u2_d_vld});
         end
         n_cmp++;
         if ({u1_i_out, u1_d_out, u2_i_out, u2_d_out} !== 128'h0) begin
            n_err++; $display("FAIL reset_out: got %h %h %h %h, want all 0", u1_i_out, u1_d_out, u2_i_out, u2_d_out);
         end
      end
      rst = 1'b0;
      repeat (4) begin
         step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
         n_cmp++;
         if ({u1_i_vld, u1_d_vld, u2_i_vld, u2_d_vld} !== 4'b0) begin
            n_err++; $display("FAIL post_reset_vld: got %b, want 0000", {u1_i_vld, u1_d_vld, u2_i_vld, u2_d_vld});
         end
      end
   endtask

   task automatic test_byte_lanes;
      step(1'b0, '0, 1'b1, 1'b1, 4'hF, 13'h010, 32'hAABBCCDD);
      step(1'b0, '0, 1'b1, 1'b1, 4'b0101, 13'h010, 32'h11223344);
      step(1'b0, '0, 1'b1, 1'b0, '0, 13'h010, '0);
      drain_check("byte_lanes");
      n_cmp++;
      if (u1_d_out !== 32'hAA22CC44 || u2_d_out !== 32'hAA22CC44) begin
         n_err++; $display("FAIL byte_lanes_word: got %h / %h, want aa22cc44", u1_d_out, u2_d_out);
      end
      hold1 = u1_d_out; hold2 = u2_d_out;
      step(1'b0, '0, 1'b1, 1'b1, 4'h0, 13'h010, 32'h0);
      step(1'b0, '0, 1'b1, 1'b1, 4'hF, 13'h011, 32'h01234567);
      idle(2);
      n_cmp++;
      if (u1_d_out !== hold1 || u2_d_out !== hold2) begin
         n_err++; $display("FAIL write_holds_dout: got %h / %h, want %h / %h", u1_d_out, u2_d_out, hold1, hold2);
      end
      step(1'b0, '0, 1'b1, 1'b0, '0, 13'h010, '0);
      step(1'b0, '0, 1'b1, 1'b0, '0, 13'h011, '0);
      drain_check("be_zero");
   endtask

   task automatic test_collision;
      step(1'b0, '0, 1'b1, 1'b1, 4'hF, 13'h1FF, 32'h0);
      step(1'b1, 13'h1FF, 1'b1, 1'b1, 4'hF, 13'h1FF, 32'hDEADBEEF);
      step(1'b1, 13'h1FF, 1'b0, 1'b0, '0, '0, '0);
      drain_check("collision");
   endtask

   task automatic test_streaming;
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 4'hF, 13'(i), (32'(i) * 32'h11111111) ^ 32'h5A5A5A5A);
      step(1'b0, '0, 1'b1, 1'b1, 4'hF, 13'h1FFF, 32'hFEEDFACE);
      for (int i = 0; i < 8; i++) step(1'b1, 13'(i), 1'b1, 1'b0, '0, 13'(7 - i), '0);
      step(1'b1, 13'h1FFF, 1'b1, 1'b0, '0, 13'h0000, '0);
      step(1'b1, 13'h0000, 1'b1, 1'b0, '0, 13'h1FFF, '0);
      drain_check("streaming");
   endtask

   task automatic test_reset_mid_read;
      step(1'b0, '0, 1'b1, 1'b1, 4'hF, 13'h040, 32'h5A5A5A5A);
      idle(3);
      i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 13'h040;
      qd1.push_back('{d: model[13'h040], p: 1'b0, t: cyc});
      @(posedge clk); #1;
      rst = 1'b1; d_we = 1'b1; d_be = 4'hF; d_in = 32'hFFFFFFFF;
      @(posedge clk); #1;
      n_cmp++;
      if (u2_d_vld !== 1'b0 || u2_d_out !== 32'h0) begin
         n_err++; $display("FAIL mid_read_lat2: vld %b out %h, want 0 00000000", u2_d_vld, u2_d_out);
      end
      n_cmp++;
      if (u1_d_vld !== 1'b0 || u1_d_out !== 32'h0) begin
         n_err++; $display("FAIL mid_read_lat1: vld %b out %h, want 0 00000000", u1_d_vld, u1_d_out);
      end
      rst = 1'b0;
      drain_check("mid_read");
      step(1'b0, '0, 1'b1, 1'b0, '0, 13'h040, '0);
      drain_check("rst_write_drop");
   endtask

   task automatic test_parity;
      step(1'b0, '0, 1'b1, 1'b1, 4'hF, 13'h080, 32'h000000FF);
      idle(2);
`ifdef MEM_PARITY_EN
      u1.mem_q[13'h080][0] = ~u1.mem_q[13'h080][0];
      u2.mem_q[13'h080][0] = ~u2.mem_q[13'h080][0];
      model[13'h080][0] = ~model[13'h080][0];
      d_perr_exp = 1'b1;
`endif
      step(1'b0, '0, 1'b1, 1'b0, '0, 13'h080, '0);
      d_perr_exp = 1'b0;
      step(1'b0, '0, 1'b1, 1'b0, '0, 13'h010, '0);
      drain_check("parity");
      n_cmp++;
      if (u1_d_perr !== 1'b0 || u2_d_perr !== 1'b0) begin
         n_err++; $display("FAIL parity_clean: got %b / %b, want 0 / 0", u1_d_perr, u2_d_perr);
      end
   endtask

   initial begin
      test_reset;
      test_byte_lanes;
      test_collision;
      test_streaming;
      test_reset_mid_read;
      test_parity;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
